scan_seq_3to8: RTL

SCAN_SEQ_3TO8 -- requirements
Module: scan_seq_3to8

---
 rtl/scan_seq_3to8.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/scan_seq_3to8.sv
// Scan sequencer for a 3-to-8 decoder select: steps through enabled addresses with a programmable dwell.
// Optional macro SCAN_SKIP_EN honours the per-address skip mask; without it all eight addresses are visited.
module scan_seq_3to8 #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         skip,
    output logic [2:0]         a,
    output logic               a_valid,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state_q;
    logic [2:0]         a_q;
    logic               a_valid_q, busy_q, done_q, wrap_q, cont_q;
    logic [DWELL_W-1:0] dwell_q, cnt_q;
    logic [7:0]         en_q;

    logic [7:0]         en_d;
    logic [2:0]         first_a_d, next_a_d, last_a_d;
    logic [DWELL_W-1:0] ld_start_d, ld_scan_d;
    logic               is_last_d;

`ifdef SCAN_SKIP_EN
    assign en_d = ~skip;
`else
    logic unused_skip;
    assign unused_skip = ^skip;
    assign en_d        = 8'hFF;
`endif

    function automatic logic [2:0] first_en(input logic [7:0] m);
        logic [2:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) r = 3'(i);
        return r;
    endfunction

    function automatic logic [2:0] last_en(input logic [7:0] m);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            if (m[i]) r = 3'(i);
        return r;
    endfunction

    // Nearest enabled address above cur, modulo 8; cur itself when it is the only one.
    function automatic logic [2:0] next_en(input logic [7:0] m, input logic [2:0] cur);
        logic [2:0] r;
        r = cur;
        for (int i = 7; i >= 1; i--)
            if (m[3'(cur + 3'(i))]) r = 3'(cur + 3'(i));
        return r;
    endfunction

    function automatic logic [DWELL_W-1:0] reload(input logic [DWELL_W-1:0] d);
        return (d == '0) ? '0 : d - DWELL_W'(1);
    endfunction

    assign first_a_d  = first_en(en_d);
    assign next_a_d   = next_en(en_q, a_q);
    assign last_a_d   = last_en(en_q);
    assign is_last_d  = (a_q == last_a_d);
    assign ld_start_d = reload(dwell);
    assign ld_scan_d  = reload(dwell_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            a_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
            cont_q    <= 1'b0;
            dwell_q   <= '0;
            cnt_q     <= '0;
            en_q      <= '0;
        end else begin
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        cont_q  <= cont;
                        dwell_q <= dwell;
                        en_q    <= en_d;
                        cnt_q   <= ld_start_d;
                        if (en_d == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= SCAN;
                            a_q       <= first_a_d;
                            a_valid_q <= 1'b1;
                            busy_q    <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    // stop outranks both the dwell countdown and any advance/wrap
                    if (stop) begin
                        state_q   <= IDLE;
                        a_q       <= '0;
                        a_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                        cnt_q     <= '0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - DWELL_W'(1);
                    end else if (is_last_d && !cont_q) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        a_q       <= '0;
                        a_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else begin
                        a_q    <= next_a_d;
                        wrap_q <= is_last_d;
                        cnt_q  <= ld_scan_d;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a       = a_q;
    assign a_valid = a_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign wrap    = wrap_q;

endmodule
